// File: rtl/hazard_ctrl_if.sv
// ============================================================================
//  Module      : hazard_ctrl_if
//  Description : D-stage instruction/class inputs and hazard-control outputs
//                (stall, bubble, forwarding selects, stall counter).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface hazard_ctrl_if #(
    parameter int PERF_W = 16
);
    logic [31:0]       instr_d;
    logic [3:0]        itype_d;
    logic              stall;
    logic              flush_e;
    logic [1:0]        fwd_rs_d;
    logic [1:0]        fwd_rt_d;
    logic [1:0]        fwd_rs_e;
    logic [1:0]        fwd_rt_e;
    logic              fwd_rt_m;
    logic [PERF_W-1:0] stall_cnt;

    modport master (
        output instr_d, itype_d,
        input  stall, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e,
               fwd_rt_m, stall_cnt
    );

    modport slave (
        input  instr_d, itype_d,
        output stall, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e,
               fwd_rt_m, stall_cnt
    );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Tuse/Tnew hazard controller for a 5-stage MIPS pipeline with
//                stall/bubble generation, forwarding selects, stall counter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int         PERF_W   = 16,
    parameter logic [4:0] LINK_REG = 5'd31
) (
    input  wire logic clk,
    input  wire logic reset,
    hazard_ctrl_if.slave bus
);

    localparam logic [3:0] c_CLS_OTHER = 4'd0;
    localparam logic [3:0] c_CLS_R     = 4'd1;
    localparam logic [3:0] c_CLS_IMM   = 4'd2;
    localparam logic [3:0] c_CLS_BEQ   = 4'd3;
    localparam logic [3:0] c_CLS_LOAD  = 4'd4;
    localparam logic [3:0] c_CLS_JR    = 4'd5;
    localparam logic [3:0] c_CLS_JAL   = 4'd6;
    localparam logic [3:0] c_CLS_STORE = 4'd7;

    localparam logic [1:0] c_SEL_RF  = 2'd0;
    localparam logic [1:0] c_SEL_E   = 2'd1;
    localparam logic [1:0] c_SEL_M   = 2'd2;
    localparam logic [1:0] c_SEL_W   = 2'd3;

    localparam logic [PERF_W-1:0] c_CNT_MAX = '1;

    // E/M/W shadow records
    logic [3:0]        r_cls_e;
    logic [4:0]        r_rs_e;
    logic [4:0]        r_rt_e;
    logic [4:0]        r_dest_e;
    logic [1:0]        r_tnew_e;
    logic [3:0]        r_cls_m;
    logic [4:0]        r_rt_m;
    logic [4:0]        r_dest_m;
    logic [1:0]        r_tnew_m;
    logic [4:0]        r_dest_w;
    logic [PERF_W-1:0] r_stall_cnt;

    logic [4:0] w_rs_d;
    logic [4:0] w_rt_d;
    logic [4:0] w_rd_d;
    logic [4:0] w_dest_d;
    logic [1:0] w_tnew_d;
    logic       w_rs_read;
    logic       w_rt_read;
    logic [1:0] w_tuse_rs;
    logic [1:0] w_tuse_rt;
    logic       w_haz_rs;
    logic       w_haz_rt;
    logic       w_stall;
    logic       w_unused_bits;

    assign w_rs_d = bus.instr_d[25:21];
    assign w_rt_d = bus.instr_d[20:16];
    assign w_rd_d = bus.instr_d[15:11];
    assign w_unused_bits = ^{bus.instr_d[31:26], bus.instr_d[10:0]};

    always_comb begin
        w_dest_d  = 5'd0;
        w_tnew_d  = 2'd0;
        w_rs_read = 1'b0;
        w_rt_read = 1'b0;
        w_tuse_rs = 2'd0;
        w_tuse_rt = 2'd0;
        case (bus.itype_d)
            c_CLS_R: begin
                w_dest_d  = w_rd_d;
                w_tnew_d  = 2'd1;
                w_rs_read = 1'b1;
                w_tuse_rs = 2'd1;
                w_rt_read = 1'b1;
                w_tuse_rt = 2'd1;
            end
            c_CLS_IMM: begin
                w_dest_d  = w_rt_d;
                w_tnew_d  = 2'd1;
                w_rs_read = 1'b1;
                w_tuse_rs = 2'd1;
            end
            c_CLS_BEQ: begin
                w_rs_read = 1'b1;
                w_rt_read = 1'b1;
            end
            c_CLS_LOAD: begin
                w_dest_d  = w_rt_d;
                w_tnew_d  = 2'd2;
                w_rs_read = 1'b1;
                w_tuse_rs = 2'd1;
            end
            c_CLS_JR: begin
                w_rs_read = 1'b1;
            end
            c_CLS_JAL: begin
                w_dest_d  = LINK_REG;
            end
            c_CLS_STORE: begin
                w_rs_read = 1'b1;
                w_tuse_rs = 2'd1;
                w_rt_read = 1'b1;
                w_tuse_rt = 2'd2;
            end
            default: begin
                w_dest_d  = 5'd0;
            end
        endcase
    end

    // A read stalls while the producer's result is due later than it is needed
    assign w_haz_rs = w_rs_read && (w_rs_d != 5'd0) &&
                      (((w_rs_d == r_dest_e) && (r_tnew_e > w_tuse_rs)) ||
                       ((w_rs_d == r_dest_m) && (r_tnew_m > w_tuse_rs)));
    assign w_haz_rt = w_rt_read && (w_rt_d != 5'd0) &&
                      (((w_rt_d == r_dest_e) && (r_tnew_e > w_tuse_rt)) ||
                       ((w_rt_d == r_dest_m) && (r_tnew_m > w_tuse_rt)));
    assign w_stall  = w_haz_rs || w_haz_rt;

    function automatic logic [1:0] f_fwd_d(
        input logic [4:0] f,
        input logic [4:0] dest_e,
        input logic [1:0] tnew_e,
        input logic [4:0] dest_m,
        input logic [1:0] tnew_m,
        input logic [4:0] dest_w
    );
        logic [1:0] sel;
        sel = c_SEL_RF;
        if (f != 5'd0) begin
            if ((f == dest_e) && (tnew_e == 2'd0))
                sel = c_SEL_E;
            else if ((f == dest_m) && (tnew_m == 2'd0))
                sel = c_SEL_M;
            else if (f == dest_w)
                sel = c_SEL_W;
        end
        return sel;
    endfunction

    function automatic logic [1:0] f_fwd_e(
        input logic [4:0] f,
        input logic [4:0] dest_m,
        input logic [1:0] tnew_m,
        input logic [4:0] dest_w
    );
        logic [1:0] sel;
        sel = c_SEL_RF;
        if (f != 5'd0) begin
            if ((f == dest_m) && (tnew_m == 2'd0))
                sel = c_SEL_M;
            else if (f == dest_w)
                sel = c_SEL_W;
        end
        return sel;
    endfunction

    assign bus.stall     = w_stall;
    assign bus.flush_e   = w_stall;
    assign bus.fwd_rs_d  = f_fwd_d(w_rs_d, r_dest_e, r_tnew_e, r_dest_m, r_tnew_m, r_dest_w);
    assign bus.fwd_rt_d  = f_fwd_d(w_rt_d, r_dest_e, r_tnew_e, r_dest_m, r_tnew_m, r_dest_w);
    assign bus.fwd_rs_e  = f_fwd_e(r_rs_e, r_dest_m, r_tnew_m, r_dest_w);
    assign bus.fwd_rt_e  = f_fwd_e(r_rt_e, r_dest_m, r_tnew_m, r_dest_w);
    assign bus.fwd_rt_m  = (r_cls_m == c_CLS_STORE) && (r_rt_m != 5'd0) &&
                           (r_rt_m == r_dest_w);
    assign bus.stall_cnt = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cls_e     <= c_CLS_OTHER;
            r_rs_e      <= 5'd0;
            r_rt_e      <= 5'd0;
            r_dest_e    <= 5'd0;
            r_tnew_e    <= 2'd0;
            r_cls_m     <= c_CLS_OTHER;
            r_rt_m      <= 5'd0;
            r_dest_m    <= 5'd0;
            r_tnew_m    <= 2'd0;
            r_dest_w    <= 5'd0;
            r_stall_cnt <= '0;
        end else begin
            r_dest_w <= r_dest_m;
            r_cls_m  <= r_cls_e;
            r_rt_m   <= r_rt_e;
            r_dest_m <= r_dest_e;
            r_tnew_m <= (r_tnew_e == 2'd0) ? 2'd0 : r_tnew_e - 2'd1;
            if (w_stall) begin
                r_cls_e  <= c_CLS_OTHER;
                r_rs_e   <= 5'd0;
                r_rt_e   <= 5'd0;
                r_dest_e <= 5'd0;
                r_tnew_e <= 2'd0;
            end else begin
                r_cls_e  <= bus.itype_d;
                r_rs_e   <= w_rs_d;
                r_rt_e   <= w_rt_d;
                r_dest_e <= w_dest_d;
                r_tnew_e <= w_tnew_d;
            end
            if (w_stall && (r_stall_cnt != c_CNT_MAX))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Scoreboard bench for hazard_ctrl; a second instance with a
//                2-bit counter shares the stimulus to exercise saturation.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.PERF_W(16)) bus1 ();
    hazard_ctrl_if #(.PERF_W(2))  bus2 ();

    hazard_ctrl #(.PERF_W(16), .LINK_REG(5'd31)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    hazard_ctrl #(.PERF_W(2), .LINK_REG(5'd31)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    typedef struct {
        int         id;
        logic       stall;
        logic [1:0] frsd;
        logic [1:0] frtd;
        logic [1:0] frse;
        logic [1:0] frte;
        logic       frtm;
        int         cnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [3:0] c_OTH = 4'd0, c_R = 4'd1, c_IMM = 4'd2, c_BEQ = 4'd3;
    localparam logic [3:0] c_LW  = 4'd4, c_JR = 4'd5, c_JAL = 4'd6, c_SW = 4'd7;

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd);
        return {6'd0, rs, rt, rd, 11'd0};
    endfunction

    task automatic drive(input logic rst, input logic [3:0] ity, input logic [31:0] ins);
        @(posedge clk);
        #1;
        reset        = rst;
        bus1.itype_d = ity;
        bus1.instr_d = ins;
        bus2.itype_d = ity;
        bus2.instr_d = ins;
    endtask

    task automatic vec(input int id, input logic [3:0] ity, input logic [31:0] ins,
                       input logic st, input logic [1:0] frsd, input logic [1:0] frtd,
                       input logic [1:0] frse, input logic [1:0] frte,
                       input logic frtm, input int cnt);
        exp_t e;
        drive(1'b0, ity, ins);
        e.id = id; e.stall = st; e.frsd = frsd; e.frtd = frtd;
        e.frse = frse; e.frte = frte; e.frtm = frtm; e.cnt = cnt;
        sb_q.push_back(e);
    endtask

    // Monitor: compares whatever expectation is pending mid-cycle
    initial begin
        exp_t       e;
        logic [9:0] act;
        logic [9:0] req;
        int         sat;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {bus1.stall, bus1.flush_e, bus1.fwd_rs_d, bus1.fwd_rt_d,
                       bus1.fwd_rs_e, bus1.fwd_rt_e, bus1.fwd_rt_m};
                req = {e.stall, e.stall, e.frsd, e.frtd, e.frse, e.frte, e.frtm};
                checks++;
                if (act !== req) begin
                    errors++;
                    $display("FAIL vec%0d ctrl {stall,flush,rsd,rtd,rse,rte,rtm}: got %b want %b",
                             e.id, act, req);
                end
                checks++;
                if (bus1.stall_cnt !== 16'(e.cnt)) begin
                    errors++;
                    $display("FAIL vec%0d stall_cnt: got %0d want %0d", e.id, bus1.stall_cnt, e.cnt);
                end
                sat = (e.cnt > 3) ? 3 : e.cnt;
                checks++;
                if (bus2.stall_cnt !== 2'(sat)) begin
                    errors++;
                    $display("FAIL vec%0d stall_cnt_sat: got %0d want %0d", e.id, bus2.stall_cnt, sat);
                end
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus1.itype_d = c_OTH; bus1.instr_d = 32'd0;
        bus2.itype_d = c_OTH; bus2.instr_d = 32'd0;
        drive(1'b1, c_OTH, 32'd0);
        drive(1'b1, c_OTH, 32'd0);

        //   id  class  instr                stall rsd rtd rse rte rtm cnt
        vec( 1, c_OTH, 32'd0,                0, 0, 0, 0, 0, 0, 0);
        // lw $2 then beq $2,$3
        vec( 2, c_LW,  mk(5'd1, 5'd2, 5'd0), 0, 0, 0, 0, 0, 0, 0);
        vec( 3, c_BEQ, mk(5'd2, 5'd3, 5'd0), 1, 0, 0, 0, 0, 0, 0);
        vec( 4, c_BEQ, mk(5'd2, 5'd3, 5'd0), 1, 0, 0, 0, 0, 0, 1);
        vec( 5, c_BEQ, mk(5'd2, 5'd3, 5'd0), 0, 3, 0, 0, 0, 0, 2);
        // lw $2 then addu $4,$2,$5
        vec( 6, c_LW,  mk(5'd1, 5'd2, 5'd0), 0, 0, 0, 0, 0, 0, 2);
        vec( 7, c_R,   mk(5'd2, 5'd5, 5'd4), 1, 0, 0, 0, 0, 0, 2);
        vec( 8, c_R,   mk(5'd2, 5'd5, 5'd4), 0, 0, 0, 0, 0, 0, 3);
        vec( 9, c_OTH, 32'd0,                0, 0, 0, 3, 0, 0, 3);
        // addu $8 then addu $9,$8,$8
        vec(10, c_R,   mk(5'd1, 5'd2, 5'd8), 0, 0, 0, 0, 0, 0, 3);
        vec(11, c_R,   mk(5'd8, 5'd8, 5'd9), 0, 0, 0, 0, 0, 0, 3);
        vec(12, c_OTH, 32'd0,                0, 0, 0, 2, 2, 0, 3);
        // jal then jr $31; the lw after sees jr's rs=31 forwarded from M
        vec(13, c_JAL, 32'h0C00_0010,        0, 0, 0, 0, 0, 0, 3);
        vec(14, c_JR,  mk(5'd31, 5'd0, 5'd0),0, 1, 0, 0, 0, 0, 3);
        // lw $7 then sw $7
        vec(15, c_LW,  mk(5'd1, 5'd7, 5'd0), 0, 0, 0, 2, 0, 0, 3);
        vec(16, c_SW,  mk(5'd1, 5'd7, 5'd0), 0, 0, 0, 0, 0, 0, 3);
        vec(17, c_OTH, 32'd0,                0, 0, 0, 0, 0, 0, 3);
        vec(18, c_OTH, 32'd0,                0, 0, 0, 0, 0, 1, 3);
        // ori $0 then addu $3,$0,$0
        vec(19, c_IMM, mk(5'd1, 5'd0, 5'd0), 0, 0, 0, 0, 0, 0, 3);
        vec(20, c_R,   mk(5'd0, 5'd0, 5'd3), 0, 0, 0, 0, 0, 0, 3);
        // reset during a lw-use stall
        vec(21, c_LW,  mk(5'd1, 5'd2, 5'd0), 0, 0, 0, 0, 0, 0, 3);
        drive(1'b1, c_R, mk(5'd2, 5'd5, 5'd4));
        vec(22, c_R,   mk(5'd2, 5'd5, 5'd4), 0, 0, 0, 0, 0, 0, 0);
        // simultaneous rs/rt hazard, then both forwarded from M
        vec(23, c_BEQ, mk(5'd4, 5'd4, 5'd0), 1, 0, 0, 0, 0, 0, 0);
        vec(24, c_BEQ, mk(5'd4, 5'd4, 5'd0), 0, 2, 2, 0, 0, 0, 1);
        // five stall cycles: 2-bit counter must hold at 3
        drive(1'b1, c_OTH, 32'd0);
        vec(25, c_LW,  mk(5'd1, 5'd2, 5'd0), 0, 0, 0, 0, 0, 0, 0);
        vec(26, c_BEQ, mk(5'd2, 5'd3, 5'd0), 1, 0, 0, 0, 0, 0, 0);
        vec(27, c_BEQ, mk(5'd2, 5'd3, 5'd0), 1, 0, 0, 0, 0, 0, 1);
        vec(28, c_BEQ, mk(5'd2, 5'd3, 5'd0), 0, 3, 0, 0, 0, 0, 2);
        vec(29, c_LW,  mk(5'd1, 5'd2, 5'd0), 0, 0, 0, 0, 0, 0, 2);
        vec(30, c_BEQ, mk(5'd2, 5'd3, 5'd0), 1, 0, 0, 0, 0, 0, 2);
        vec(31, c_BEQ, mk(5'd2, 5'd3, 5'd0), 1, 0, 0, 0, 0, 0, 3);
        vec(32, c_BEQ, mk(5'd2, 5'd3, 5'd0), 0, 3, 0, 0, 0, 0, 4);
        vec(33, c_LW,  mk(5'd1, 5'd2, 5'd0), 0, 0, 0, 0, 0, 0, 4);
        vec(34, c_R,   mk(5'd2, 5'd5, 5'd4), 1, 0, 0, 0, 0, 0, 4);
        vec(35, c_R,   mk(5'd2, 5'd5, 5'd4), 0, 0, 0, 0, 0, 0, 5);

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
